// File: rtl/if_fetch.sv
`default_nettype none
// ============================================================================
//  Module      : if_fetch
//  Description : Instruction-fetch stage. Assembles each 32-bit instruction
//                from four little-endian byte reads on the shared byte port,
//                presents it to IF/ID and requests a stall until then.
//                Branch/jump redirects squash in-flight and held fetches.
//                Optional macro IF_ICACHE_EN adds a direct-mapped icache.
//  Revision    : 1.0  initial release
// ============================================================================
module if_fetch #(
    parameter logic [31:0] ENTRY_PC     = 32'h0000_0000,
    parameter int          ICACHE_IDX_W = 5
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [5:0]  stall,
    input  logic        branch_en,
    input  logic [31:0] branch_target,
    input  logic        mem_ready,
    input  logic [7:0]  mem_rdata,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    output logic [31:0] if_pc,
    output logic [31:0] if_inst,
    output logic        stallreq_if
);

    typedef enum logic [0:0] {
        S_FETCH = 1'b0,
        S_HOLD  = 1'b1
    } state_t;

    state_t      r_state;
    state_t      w_state_next;
    logic [31:0] r_pc;
    logic [31:0] r_inst;
    logic [2:0]  r_req_cnt;
    logic [2:0]  r_rcv_cnt;
    logic        r_acc_d;       // a request was accepted last cycle

    logic        w_valid;
    logic        w_issue;
    logic        w_accept;
    logic        w_latch;
    logic        w_word_done;
    logic        w_consume;
    logic        w_hit;
    logic [31:0] w_hit_word;
    logic        w_unused_bits;

    assign w_valid     = (r_state == S_HOLD);
    // Redirect and reset both silence the memory port in their cycle.
    assign w_issue     = !rst && !branch_en && (r_state == S_FETCH)
                         && (r_req_cnt != 3'd4) && !w_hit;
    assign w_accept    = w_issue && mem_ready;
    // A byte returning in a redirect cycle belongs to the squashed fetch.
    assign w_latch     = r_acc_d && !branch_en && !rst;
    assign w_word_done = w_latch && (r_rcv_cnt == 3'd3);
    assign w_consume   = w_valid && !stall[1];

    assign w_unused_bits = ^{stall[5:2], stall[0], branch_target[1:0]};

`ifdef IF_ICACHE_EN
    localparam int LINES = 1 << ICACHE_IDX_W;
    localparam int TAG_W = 32 - ICACHE_IDX_W - 2;

    logic [LINES-1:0]        r_line_vld;
    logic [TAG_W-1:0]        r_tag  [LINES];
    logic [31:0]             r_word [LINES];
    logic [ICACHE_IDX_W-1:0] w_idx;
    logic [TAG_W-1:0]        w_tag;

    assign w_idx      = r_pc[ICACHE_IDX_W+1:2];
    assign w_tag      = r_pc[31:ICACHE_IDX_W+2];
    // Lookup only before any byte of this pc has been requested.
    assign w_hit      = (r_state == S_FETCH) && (r_req_cnt == 3'd0)
                        && (r_rcv_cnt == 3'd0) && r_line_vld[w_idx]
                        && (r_tag[w_idx] == w_tag);
    assign w_hit_word = r_word[w_idx];

    // Line valid bits: cleared by reset, set when a fill completes.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_line_vld <= '0;
        end else if (w_word_done) begin
            r_line_vld[w_idx] <= 1'b1;
        end
    end

    // Tag/data write on fill completion (aborted fills never reach here).
    always_ff @(posedge clk) begin
        if (!rst && w_word_done) begin
            r_tag[w_idx]  <= w_tag;
            r_word[w_idx] <= {mem_rdata, r_inst[23:0]};
        end
    end
`else
    logic [31:0] w_unused_cfg;

    assign w_unused_cfg = ICACHE_IDX_W;
    assign w_hit        = 1'b0;
    assign w_hit_word   = 32'h0;
`endif

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_FETCH;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next state: word assembled (or cache hit) enters HOLD, consume leaves it.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_FETCH: if (w_word_done || w_hit) w_state_next = S_HOLD;
            S_HOLD:  if (!stall[1])            w_state_next = S_FETCH;
            default: w_state_next = S_FETCH;
        endcase
        if (branch_en) begin
            w_state_next = S_FETCH;
        end
    end

    // PC, request/receive counters and instruction assembly.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pc      <= ENTRY_PC;
            r_req_cnt <= 3'd0;
            r_rcv_cnt <= 3'd0;
            r_acc_d   <= 1'b0;
            r_inst    <= 32'h0;
        end else if (branch_en) begin
            r_pc      <= {branch_target[31:2], 2'b00};
            r_req_cnt <= 3'd0;
            r_rcv_cnt <= 3'd0;
            r_acc_d   <= 1'b0;
        end else begin
            r_acc_d <= w_accept;
            if (w_consume) begin
                r_pc      <= r_pc + 32'd4;
                r_req_cnt <= 3'd0;
                r_rcv_cnt <= 3'd0;
            end else begin
                if (w_accept) begin
                    r_req_cnt <= r_req_cnt + 3'd1;
                end
                if (w_latch) begin
                    r_inst[{r_rcv_cnt[1:0], 3'b000} +: 8] <= mem_rdata;
                    r_rcv_cnt <= r_rcv_cnt + 3'd1;
                end
                if (w_hit) begin
                    r_inst <= w_hit_word;
                end
            end
        end
    end

    assign mem_req     = w_issue;
    assign mem_addr    = r_pc + {29'd0, r_req_cnt};
    assign if_pc       = w_valid ? r_pc   : 32'h0;
    assign if_inst     = w_valid ? r_inst : 32'h0;
    assign stallreq_if = !w_valid;

endmodule
`default_nettype wire

// File: tb/tb_if_fetch.sv
`default_nettype none
// ============================================================================
//  Module      : tb_if_fetch
//  Description : Self-checking bench for if_fetch. Byte memory model, directed
//                stimulus, scoreboard queues for request addresses and
//                presented instructions checked by a negedge monitor.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_if_fetch;

    logic        clk = 1'b0;
    logic        rst;
    logic [5:0]  stall;
    logic        branch_en;
    logic [31:0] branch_target;
    logic        mem_ready;
    logic [7:0]  mem_rdata;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic [31:0] if_pc;
    logic [31:0] if_inst;
    logic        stallreq_if;

    int n_checks = 0;
    int n_fail   = 0;

    logic [31:0] exp_addr_q [$];
    logic [63:0] exp_inst_q [$];   // {pc, inst}
    logic        r_prev_valid = 1'b0;

    if_fetch #(.ENTRY_PC(32'h0000_0000), .ICACHE_IDX_W(5)) dut (
        .clk           (clk),
        .rst           (rst),
        .stall         (stall),
        .branch_en     (branch_en),
        .branch_target (branch_target),
        .mem_ready     (mem_ready),
        .mem_rdata     (mem_rdata),
        .mem_req       (mem_req),
        .mem_addr      (mem_addr),
        .if_pc         (if_pc),
        .if_inst       (if_inst),
        .stallreq_if   (stallreq_if)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] mem_byte(input logic [31:0] a);
        case (a)
            32'h000: mem_byte = 8'h13;
            32'h001: mem_byte = 8'h05;
            32'h002: mem_byte = 8'hA0;
            32'h003: mem_byte = 8'h00;
            32'h004: mem_byte = 8'h93;
            32'h005: mem_byte = 8'h05;
            32'h006: mem_byte = 8'h10;
            32'h007: mem_byte = 8'h00;
            32'h008: mem_byte = 8'h13;
            32'h009: mem_byte = 8'h06;
            32'h00A: mem_byte = 8'h20;
            32'h00B: mem_byte = 8'h00;
            32'h100: mem_byte = 8'hEF;
            32'h101: mem_byte = 8'hBE;
            32'h102: mem_byte = 8'hAD;
            32'h103: mem_byte = 8'hDE;
            default: mem_byte = a[7:0] ^ 8'h5A;
        endcase
    endfunction

    // Memory: byte returned the cycle after acceptance.
    always @(posedge clk) begin
        if (mem_req && mem_ready) mem_rdata <= mem_byte(mem_addr);
        else                      mem_rdata <= 8'hEE;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Monitor: accepted requests and newly presented instructions.
    always @(negedge clk) begin
        if (mem_req === 1'b1 && mem_ready === 1'b1) begin
            if (exp_addr_q.size() == 0) begin
                chk("unexpected_req", mem_addr, 32'hFFFF_FFFF);
            end else begin
                chk("req_addr", mem_addr, exp_addr_q.pop_front());
            end
        end
        if (stallreq_if === 1'b0 && !r_prev_valid) begin
            if (exp_inst_q.size() == 0) begin
                chk("unexpected_inst", if_pc, 32'hFFFF_FFFF);
            end else begin
                logic [63:0] e;
                e = exp_inst_q.pop_front();
                chk("inst_pc", if_pc, e[63:32]);
                chk("inst_word", if_inst, e[31:0]);
            end
        end
        r_prev_valid <= (stallreq_if === 1'b0);
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic wait_valid(input int bound, input string nm);
        bit seen = 1'b0;
        for (int i = 0; i < bound; i++) begin
            if (stallreq_if === 1'b0) begin
                seen = 1'b1;
                break;
            end
            tick();
        end
        if (!seen) chk(nm, 32'd0, 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [6:0] exp_req;
        exp_req = 7'b1001111;   // bit c: mem_req expected in cycle c

        // Expected request addresses, in order.
        for (int a = 0; a < 12; a++) exp_addr_q.push_back(32'(a));
        exp_addr_q.push_back(32'h00C);
        exp_addr_q.push_back(32'h00D);
        exp_addr_q.push_back(32'h00E);
        for (int a = 0; a < 4; a++) exp_addr_q.push_back(32'h100 + 32'(a));
        exp_addr_q.push_back(32'h200);
        exp_addr_q.push_back(32'h201);
        for (int a = 0; a < 4; a++) exp_addr_q.push_back(32'(a));
        // Expected presentations.
        exp_inst_q.push_back({32'h000, 32'h00A0_0513});
        exp_inst_q.push_back({32'h004, 32'h0010_0593});
        exp_inst_q.push_back({32'h008, 32'h0020_0613});
        exp_inst_q.push_back({32'h100, 32'hDEAD_BEEF});
        exp_inst_q.push_back({32'h000, 32'h00A0_0513});

        rst = 1'b1; stall = 6'b000001; branch_en = 1'b0;
        branch_target = 32'h0; mem_ready = 1'b1;
        tick();
        tick();
        chk("rst_stallreq", {31'd0, stallreq_if}, 32'd1);
        chk("rst_if_pc", if_pc, 32'h0);
        chk("rst_if_inst", if_inst, 32'h0);
        chk("rst_mem_req", {31'd0, mem_req}, 32'd0);
        tick();
        rst = 1'b0;
        #1;

        // Zero-wait fetch, cycle-exact; stall[0] alone must not matter.
        for (int c = 0; c < 7; c++) begin
            if (c > 0) tick();
            chk("za_mem_req", {31'd0, mem_req}, {31'd0, exp_req[c]});
            if (exp_req[c]) chk("za_mem_addr", mem_addr, (c == 6) ? 32'd4 : 32'(c));
            if (c == 4) chk("za_stallreq_c4", {31'd0, stallreq_if}, 32'd1);
            if (c == 5) begin
                chk("za_stallreq_c5", {31'd0, stallreq_if}, 32'd0);
                chk("za_if_pc", if_pc, 32'h0);
                chk("za_if_inst", if_inst, 32'h00A0_0513);
            end
        end
        stall = 6'b000011;

        // Hold for 10 cycles under stall[1].
        wait_valid(20, "timeout_hold");
        for (int i = 0; i < 10; i++) begin
            chk("hold_if_pc", if_pc, 32'h4);
            chk("hold_if_inst", if_inst, 32'h0010_0593);
            chk("hold_mem_req", {31'd0, mem_req}, 32'd0);
            tick();
        end
        stall = 6'b000000;
        tick();
        chk("release_addr", mem_addr, 32'h8);
        chk("release_stallreq", {31'd0, stallreq_if}, 32'd1);

        // Alternating mem_ready on the fetch at pc 8.
        stall = 6'b000010;
        mem_ready = 1'b0;
        for (int i = 0; i < 30; i++) begin
            tick();
            if (stallreq_if === 1'b0) break;
            mem_ready = ~mem_ready;
        end
        chk("gap_valid", {31'd0, stallreq_if}, 32'd0);
        mem_ready = 1'b1;

        // Redirect while two bytes of pc 12 have been received.
        stall = 6'b000000;
        tick();
        tick();
        tick();
        tick();
        branch_en = 1'b1; branch_target = 32'h103;
        #1;
        chk("br_mem_req", {31'd0, mem_req}, 32'd0);
        stall = 6'b000010;
        tick();
        branch_en = 1'b0;
        #1;
        chk("br_addr", mem_addr, 32'h100);
        chk("br_mem_req_next", {31'd0, mem_req}, 32'd1);
        wait_valid(20, "timeout_br");

        // Redirect during HOLD with stall[1] low: held word dropped.
        branch_en = 1'b1; branch_target = 32'h200; stall = 6'b000000;
        tick();
        branch_en = 1'b0;
        #1;
        chk("hold_br_stallreq", {31'd0, stallreq_if}, 32'd1);
        chk("hold_br_addr", mem_addr, 32'h200);

        // Reset in the middle of the fetch at 0x200.
        tick();
        tick();
        rst = 1'b1;
        #1;
        chk("midrst_mem_req", {31'd0, mem_req}, 32'd0);
        tick();
        chk("midrst_stallreq", {31'd0, stallreq_if}, 32'd1);
        chk("midrst_if_pc", if_pc, 32'h0);
        rst = 1'b0;
        stall = 6'b000010;
        #1;
        chk("midrst_addr", mem_addr, 32'h0);
        wait_valid(20, "timeout_rst");
        tick();
        tick();

        chk("addr_q_empty", 32'(exp_addr_q.size()), 32'd0);
        chk("inst_q_empty", 32'(exp_inst_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
